// File: rtl/wb_dsp_scoreboard.sv
// Multi-lane result scoreboard: per-channel expected queues compared in order
// against measured words, with tallies, first-failure capture and a verdict FSM.
module wb_dsp_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter int NUM_TESTS  = 16,
    parameter int FAIL_LIMIT = 0,
    parameter int CNT_W      = 16
) (
    input  logic                                         wb_clk,
    input  logic                                         wb_rst_n,
    input  logic                                         start,
    input  logic                                         finish,
    input  logic [CHANNELS-1:0]                          exp_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]               exp_data,
    output logic [CHANNELS-1:0]                          exp_ready,
    input  logic [CHANNELS-1:0]                          act_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]               act_data,
    input  logic [DATA_WIDTH-1:0]                        cmp_mask,
    output logic [CNT_W-1:0]                             test_count,
    output logic [CNT_W-1:0]                             fail_count,
    output logic                                         busy,
    output logic                                         test_passed,
    output logic                                         test_failed,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ff_chan,
    output logic [CNT_W-1:0]                             ff_index,
    output logic [DATA_WIDTH-1:0]                        ff_exp,
    output logic [DATA_WIDTH-1:0]                        ff_act,
    output logic [1:0]                                   ff_cause
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_PASSED, S_FAILED} state_t;

    state_t state, state_nxt;

    logic [PTR_W:0]          wr_ptr [CHANNELS];
    logic [PTR_W:0]          rd_ptr [CHANNELS];
    logic [DATA_WIDTH-1:0]   mem    [CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0]   head   [CHANNELS];
    logic [CHANNELS-1:0]     full, empty, push, pop, cmp, fail;

    logic                    run, abort, pass_cond;
    logic [CNT_W-1:0]        n_cmp, n_fail, sel_rank;
    logic                    ff_hit;
    logic [CH_W-1:0]         sel_chan;
    logic [DATA_WIDTH-1:0]   sel_exp, sel_act;
    logic [1:0]              sel_cause;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign run       = (state == S_RUN);
    assign exp_ready = run ? ~full : '0;
    // Full is taken from registered pointers, so a push to a full queue is dropped even if a pop frees a slot.
    assign push      = exp_valid & exp_ready;
    assign cmp       = run ? act_valid : '0;
    assign pop       = cmp & ~empty;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][PTR_W] != rd_ptr[c][PTR_W]) &&
                       (wr_ptr[c][PTR_W-1:0] == rd_ptr[c][PTR_W-1:0]);
            head[c]  = mem[c][rd_ptr[c][PTR_W-1:0]];
            fail[c]  = cmp[c] && (empty[c] ||
                       (((head[c] ^ act_data[c*DATA_WIDTH +: DATA_WIDTH]) & cmp_mask) != '0));
        end
    end

    // Tally this cycle's compares; the lowest failing channel is the capture candidate.
    always_comb begin
        n_cmp     = '0;
        n_fail    = '0;
        ff_hit    = 1'b0;
        sel_chan  = '0;
        sel_rank  = '0;
        sel_exp   = '0;
        sel_act   = '0;
        sel_cause = 2'b00;
        for (int c = 0; c < CHANNELS; c++) begin
            if (fail[c] && !ff_hit) begin
                ff_hit    = 1'b1;
                sel_chan  = CH_W'(c);
                sel_rank  = n_cmp;
                sel_exp   = empty[c] ? '0 : head[c];
                sel_act   = act_data[c*DATA_WIDTH +: DATA_WIDTH];
                sel_cause = empty[c] ? 2'b10 : 2'b01;
            end
            if (cmp[c])  n_cmp  = n_cmp + CNT_W'(1);
            if (fail[c]) n_fail = n_fail + CNT_W'(1);
        end
    end

    assign pass_cond = (fail_count == '0) && (test_count == CNT_W'(NUM_TESTS)) && (&empty);

    if (FAIL_LIMIT != 0) begin : g_abort
        assign abort = (fail_count >= CNT_W'(FAIL_LIMIT));
    end else begin : g_no_abort
        assign abort = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (abort) state_nxt = S_FAILED;
                         else if (finish) state_nxt = S_CHECK;
                S_CHECK: state_nxt = pass_cond ? S_PASSED : S_FAILED;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // NOTE: queue storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge wb_clk) begin
        for (int c = 0; c < CHANNELS; c++)
            if (push[c]) mem[c][wr_ptr[c][PTR_W-1:0]] <= exp_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            test_count <= '0;
            fail_count <= '0;
            ff_chan    <= '0;
            ff_index   <= '0;
            ff_exp     <= '0;
            ff_act     <= '0;
            ff_cause   <= 2'b00;
        end else if (start) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            test_count <= '0;
            fail_count <= '0;
            ff_chan    <= '0;
            ff_index   <= '0;
            ff_exp     <= '0;
            ff_act     <= '0;
            ff_cause   <= 2'b00;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
            end
            test_count <= sat_add(test_count, n_cmp);
            fail_count <= sat_add(fail_count, n_fail);
            if (ff_hit && ff_cause == 2'b00) begin
                ff_chan  <= sel_chan;
                ff_index <= sat_add(test_count, sel_rank);
                ff_exp   <= sel_exp;
                ff_act   <= sel_act;
                ff_cause <= sel_cause;
            end else if (state == S_CHECK && !pass_cond && ff_cause == 2'b00) begin
                ff_cause <= 2'b11;
                ff_index <= test_count;
            end
        end
    end

    assign busy        = (state == S_RUN) || (state == S_CHECK);
    assign test_passed = (state == S_PASSED);
    assign test_failed = (state == S_FAILED);

endmodule

// File: tb/tb_wb_dsp_scoreboard.sv
// Directed bench for wb_dsp_scoreboard: a queue-based model predicts counts,
// first-failure capture and verdicts; a second instance exercises FAIL_LIMIT.
module tb_wb_dsp_scoreboard;

    localparam int DW  = 32;
    localparam int CH  = 4;
    localparam int DEP = 4;
    localparam int NT  = 4;
    localparam int CW  = 16;

    logic              wb_clk = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic [CH-1:0]     exp_valid = '0;
    logic [CH-1:0]     act_valid = '0;
    logic [CH*DW-1:0]  exp_data = '0;
    logic [CH*DW-1:0]  act_data = '0;
    logic [DW-1:0]     cmp_mask = '1;

    logic [CH-1:0]     exp_ready, a_exp_ready;
    logic [CW-1:0]     test_count, fail_count, ff_index;
    logic [CW-1:0]     a_test_count, a_fail_count, a_ff_index;
    logic              busy, test_passed, test_failed;
    logic              a_busy, a_test_passed, a_test_failed;
    logic [1:0]        ff_chan, a_ff_chan, ff_cause, a_ff_cause;
    logic [DW-1:0]     ff_exp, ff_act, a_ff_exp, a_ff_act;

    wb_dsp_scoreboard #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEP), .NUM_TESTS(NT),
                        .FAIL_LIMIT(0), .CNT_W(CW)) u_dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .finish(finish),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .act_valid(act_valid), .act_data(act_data), .cmp_mask(cmp_mask),
        .test_count(test_count), .fail_count(fail_count), .busy(busy),
        .test_passed(test_passed), .test_failed(test_failed), .ff_chan(ff_chan),
        .ff_index(ff_index), .ff_exp(ff_exp), .ff_act(ff_act), .ff_cause(ff_cause));

    wb_dsp_scoreboard #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEP), .NUM_TESTS(NT),
                        .FAIL_LIMIT(2), .CNT_W(CW)) u_abort (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .finish(finish),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(a_exp_ready),
        .act_valid(act_valid), .act_data(act_data), .cmp_mask(cmp_mask),
        .test_count(a_test_count), .fail_count(a_fail_count), .busy(a_busy),
        .test_passed(a_test_passed), .test_failed(a_test_failed), .ff_chan(a_ff_chan),
        .ff_index(a_ff_index), .ff_exp(a_ff_exp), .ff_act(a_ff_act), .ff_cause(a_ff_cause));

    always #5 wb_clk = ~wb_clk;

    // Reference model of the main instance
    logic [DW-1:0] mq [CH][$];
    int            m_tc, m_fc, m_chan, m_index;
    logic [1:0]    m_cause;
    logic [DW-1:0] m_exp, m_act;
    logic          m_run = 1'b0;
    logic          m_pass;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_tc = 0; m_fc = 0; m_chan = 0; m_index = 0;
        m_cause = 2'b00; m_exp = '0; m_act = '0;
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_exp(input int c, input logic [DW-1:0] v);
        exp_data[c*DW +: DW] = v;
    endtask

    task automatic set_act(input int c, input logic [DW-1:0] v);
        act_data[c*DW +: DW] = v;
    endtask

    // One clock of stimulus; the model consumes heads before accepting pushes (no bypass)
    task automatic step(input logic st, input logic fin, input logic [CH-1:0] ev,
                        input logic [CH-1:0] av);
        int            sz [CH];
        logic          hit;
        logic          bad;
        logic [DW-1:0] hd, aw;
        start = st; finish = fin; exp_valid = ev; act_valid = av;
        if (st) begin
            model_clear();
            m_run = 1'b1;
        end else if (m_run) begin
            hit = 1'b0;
            for (int c = 0; c < CH; c++) sz[c] = mq[c].size();
            for (int c = 0; c < CH; c++) begin
                if (av[c]) begin
                    aw = act_data[c*DW +: DW];
                    if (sz[c] == 0) begin
                        hd  = '0;
                        bad = 1'b1;
                    end else begin
                        hd  = mq[c].pop_front();
                        bad = (((hd ^ aw) & cmp_mask) != '0);
                    end
                    if (bad) begin
                        if (!hit && m_cause == 2'b00) begin
                            m_cause = (sz[c] == 0) ? 2'b10 : 2'b01;
                            m_chan  = c;
                            m_index = m_tc;
                            m_exp   = hd;
                            m_act   = aw;
                        end
                        hit = 1'b1;
                        m_fc++;
                    end
                    m_tc++;
                end
            end
            for (int c = 0; c < CH; c++)
                if (ev[c] && sz[c] < DEP) mq[c].push_back(exp_data[c*DW +: DW]);
        end
        tick();
        start = 1'b0; finish = 1'b0; exp_valid = '0; act_valid = '0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".test_count"}, 64'(test_count), 64'(m_tc));
        check({tag, ".fail_count"}, 64'(fail_count), 64'(m_fc));
        check({tag, ".ff_cause"},   64'(ff_cause),   64'(m_cause));
        check({tag, ".ff_chan"},    64'(ff_chan),    64'(m_chan));
        check({tag, ".ff_index"},   64'(ff_index),   64'(m_index));
        check({tag, ".ff_exp"},     64'(ff_exp),     64'(m_exp));
        check({tag, ".ff_act"},     64'(ff_act),     64'(m_act));
    endtask

    task automatic verdict(input string tag);
        step(1'b0, 1'b1, '0, '0);
        m_run = 1'b0;
        check({tag, ".check_busy"},   64'(busy),        64'(1));
        check({tag, ".check_noflag"}, 64'({test_passed, test_failed}), 64'(0));
        m_pass = (m_fc == 0) && (m_tc == NT);
        for (int c = 0; c < CH; c++) if (mq[c].size() != 0) m_pass = 1'b0;
        tick();
        if (!m_pass && m_cause == 2'b00) begin
            m_cause = 2'b11;
            m_index = m_tc;
        end
        check({tag, ".passed"}, 64'(test_passed), 64'(m_pass));
        check({tag, ".failed"}, 64'(test_failed), 64'(!m_pass));
        check({tag, ".busy"},   64'(busy),        64'(0));
        check_model(tag);
    endtask

    initial begin
        #2;
        check("reset.test_count", 64'(test_count), 64'(0));
        check("reset.fail_count", 64'(fail_count), 64'(0));
        check("reset.busy",       64'(busy),       64'(0));
        check("reset.exp_ready",  64'(exp_ready),  64'(0));
        check("reset.flags",      64'({test_passed, test_failed}), 64'(0));
        check("reset.ff_cause",   64'(ff_cause),   64'(0));
        #10 wb_rst_n = 1'b1;

        // finish while idle must be ignored
        step(1'b0, 1'b1, '0, '0);
        tick();
        check("idle_finish.busy",  64'(busy), 64'(0));
        check("idle_finish.flags", 64'({test_passed, test_failed}), 64'(0));

        // pass flow on channel 0
        step(1'b1, 1'b0, '0, '0);
        check("start.busy",      64'(busy),      64'(1));
        check("start.exp_ready", 64'(exp_ready), 64'(4'hF));
        for (int i = 0; i < 4; i++) begin
            set_exp(0, 32'h11 * (i + 1));
            step(1'b0, 1'b0, 4'b0001, '0);
        end
        for (int i = 0; i < 4; i++) begin
            set_act(0, 32'h11 * (i + 1));
            step(1'b0, 1'b0, '0, 4'b0001);
        end
        check_model("pass_flow");
        verdict("pass_verdict");
        check("pass_verdict.tc4", 64'(test_count), 64'(4));

        // masked compare, then unmasked mismatch
        step(1'b1, 1'b0, '0, '0);
        cmp_mask = 32'hFFFF_FFFE;
        set_exp(0, 32'h0000_00FF); step(1'b0, 1'b0, 4'b0001, '0);
        set_act(0, 32'h0000_00FE); step(1'b0, 1'b0, '0, 4'b0001);
        check_model("masked_pass");
        cmp_mask = 32'hFFFF_FFFF;
        set_exp(0, 32'h0000_00FF); step(1'b0, 1'b0, 4'b0001, '0);
        set_act(0, 32'h0000_00FE); step(1'b0, 1'b0, '0, 4'b0001);
        check_model("masked_fail");
        check("masked_fail.cause01", 64'(ff_cause), 64'(2'b01));

        // simultaneous failures on channels 1 and 3
        step(1'b1, 1'b0, '0, '0);
        for (int c = 0; c < CH; c++) set_exp(c, 32'hA0 + c);
        step(1'b0, 1'b0, 4'hF, '0);
        set_act(0, 32'hA0); set_act(1, 32'h0); set_act(2, 32'hA2); set_act(3, 32'h0);
        step(1'b0, 1'b0, '0, 4'hF);
        check_model("same_cycle");
        check("same_cycle.chan1", 64'(ff_chan),  64'(1));
        check("same_cycle.idx1",  64'(ff_index), 64'(1));

        // underflow with an unbypassed same-cycle push, then full-queue drop
        step(1'b1, 1'b0, '0, '0);
        set_exp(2, 32'h5); set_act(2, 32'h5);
        step(1'b0, 1'b0, 4'b0100, 4'b0100);
        check_model("underflow");
        check("underflow.cause10", 64'(ff_cause), 64'(2'b10));
        for (int i = 0; i < DEP; i++) begin
            set_exp(0, 32'h100 + i);
            step(1'b0, 1'b0, 4'b0001, '0);
        end
        check("full.exp_ready", 64'(exp_ready), 64'(4'b1110));
        set_exp(0, 32'hDEAD); set_act(0, 32'h100);
        step(1'b0, 1'b0, 4'b0001, 4'b0001);
        check("full_pop.exp_ready", 64'(exp_ready), 64'(4'b1111));
        for (int i = 1; i < DEP; i++) begin
            set_act(0, 32'h100 + i);
            step(1'b0, 1'b0, '0, 4'b0001);
        end
        set_act(2, 32'h5);    step(1'b0, 1'b0, '0, 4'b0100);
        set_act(0, 32'hDEAD); step(1'b0, 1'b0, '0, 4'b0001);
        check_model("drop");

        // three passing compares and one leftover entry
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            set_exp(0, 32'h1 + i);
            step(1'b0, 1'b0, 4'b0001, '0);
        end
        for (int i = 0; i < 3; i++) begin
            set_act(0, 32'h1 + i);
            step(1'b0, 1'b0, '0, 4'b0001);
        end
        verdict("leftover");
        check("leftover.cause11", 64'(ff_cause), 64'(2'b11));
        check("leftover.idx3",    64'(ff_index), 64'(3));

        // FAIL_LIMIT=2 instance aborts one cycle after the second failure
        step(1'b1, 1'b0, '0, '0);
        set_act(0, 32'h7);
        step(1'b0, 1'b0, '0, 4'b0001);
        step(1'b0, 1'b0, '0, 4'b0001);
        check("abort.fail_count", 64'(a_fail_count), 64'(2));
        check("abort.still_run",  64'({a_busy, a_test_failed}), 64'(2'b10));
        tick();
        check("abort.failed", 64'({a_busy, a_test_failed}), 64'(2'b01));
        check("abort.main_run", 64'(busy), 64'(1));
        check_model("abort_main");

        // start and finish together: start wins, no verdict follows
        step(1'b1, 1'b1, '0, '0);
        tick();
        tick();
        check("start_wins.busy",  64'(busy), 64'(1));
        check("start_wins.flags", 64'({test_passed, test_failed}), 64'(0));

        // asynchronous reset mid-run
        set_exp(1, 32'h9);
        step(1'b0, 1'b0, 4'b0010, 4'b0001);
        check_model("pre_reset");
        #2 wb_rst_n = 1'b0;
        #1;
        check("async_rst.counts",    64'({test_count, fail_count}), 64'(0));
        check("async_rst.busy",      64'({busy, a_busy}),           64'(0));
        check("async_rst.exp_ready", 64'(exp_ready),                64'(0));
        check("async_rst.ff",        64'({ff_cause, ff_index, ff_act}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_dsp_scoreboard.md
# wb_dsp_scoreboard

Synthesizable, parametrised result scoreboard for the DSP test environment. Each of CHANNELS independent lanes queues expected words and compares them in order against measured words under a bit mask. The block keeps pass and fail tallies and captures the first failure. On `finish` it declares pass or fail against a required test count. It sits beside the DUT in simulation and FPGA self-test builds, replacing the per-call software checking with cycle-accurate hardware checking.

## Interface
Parameters:
- DATA_WIDTH, 32, width of compared words
- CHANNELS, 4, independent compare lanes (1..16)
- DEPTH, 8, expected-queue entries per channel (power of two, ≥2)
- NUM_TESTS, 16, compares required for a pass
- FAIL_LIMIT, 0, abort after this many failures (0 = never abort early)
- CNT_W, 16, counter width

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  reset. Asynchronous, active-low.
- start  in  1  clear all counts and captures, enter RUN
- finish  in  1  end of test; triggers the final verdict
- exp_valid  in  CHANNELS  push expected word, per channel
- exp_data  in  CHANNELS*DATA_WIDTH  expected words; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- exp_ready  out  CHANNELS  queue not full
- act_valid  in  CHANNELS  measured word present, per channel
- act_data  in  CHANNELS*DATA_WIDTH  measured words
- cmp_mask  in  DATA_WIDTH  1 = bit compared
- test_count  out  CNT_W  compares performed
- fail_count  out  CNT_W  failed compares
- busy  out  1  state is RUN or CHECK
- test_passed  out  1  sticky pass verdict
- test_failed  out  1  sticky fail verdict
- ff_chan  out  max(1,$clog2(CHANNELS))  first-failure channel
- ff_index  out  CNT_W  value of test_count at the first failure
- ff_exp, ff_act  out  DATA_WIDTH  first-failure expected and measured words
- ff_cause  out  2  00 none, 01 mismatch, 10 underflow, 11 count/leftover error

## Operation
- States: IDLE, RUN, CHECK, PASSED, FAILED. Reset enters IDLE.
- From IDLE, PASSED or FAILED, `start` goes to RUN. In RUN, `start` restarts the run: counters, queues and captures are cleared and the state stays RUN.
- `start` clears test_count, fail_count, all queues, ff_* and the verdict flags.
- Outside RUN, exp_valid and act_valid are ignored and exp_ready = 0.
- Push: when exp_valid[c] and exp_ready[c] are both high, the word is written to queue c. exp_ready[c] = !full[c]. A push to a full queue is dropped, even when a pop happens in the same cycle.
- Compare on act_valid[c]:
  - Queue non-empty: pop the head. Pass if ((head ^ act) & cmp_mask) == 0; otherwise fail with cause 01.
  - Queue empty: fail with cause 10. A same-cycle push is not bypassed to the compare.
- Multiple channels may compare in one cycle. test_count and fail_count each add the popcount of that cycle's compares and failures.
- First-failure capture: loaded only while ff_cause == 00. When several channels fail in the same cycle, the lowest channel index wins. ff_index = the test_count value before the increment plus the winner's rank among that cycle's compares (lower channels first).
- FAIL_LIMIT ≠ 0: when fail_count reaches FAIL_LIMIT, go RUN → FAILED directly.
- `finish` in RUN goes to CHECK. In CHECK:
  - PASSED if fail_count == 0, test_count == NUM_TESTS and all queues are empty.
  - Otherwise FAILED. If ff_cause was still 00, it is set to 11 with ff_index = test_count.
- test_passed and test_failed are high exactly in PASSED and FAILED respectively.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values: all counters, ff_* and flags are 0; exp_ready = 0; busy = 0; queues empty.
- `start` at edge N: RUN from N+1, with exp_ready high from N+1.
- A push at edge N is visible to a compare at edge N+1.
- Compare at edge N: counts and ff_* are updated after edge N. A FAIL_LIMIT abort is in FAILED after edge N+1.
- `finish` at edge N: CHECK after N. The verdict flag is asserted after N+1, so finish-to-verdict is 2 cycles.
- A compare in the same cycle as `finish` is counted before the verdict.
- `finish` outside RUN is ignored. `start` and `finish` high together: `start` wins.
- Reset asserted mid-run clears everything immediately, independent of the clock.

## Test plan
- Pass flow: NUM_TESTS=4, CHANNELS=1; push 0x11, 0x22, 0x33, 0x44; act the same values; finish. Expect test_passed 2 cycles later, test_count = 4, fail_count = 0.
- Masked mismatch: exp 0x0000_00FF, act 0x0000_00FE. With cmp_mask = 0xFFFF_FFFE → pass. With mask = 0xFFFF_FFFF → fail, ff_cause = 01, ff_exp = 0xFF, ff_act = 0xFE.
- Same-cycle failures: ch1 and ch3 mismatch in the same cycle. Expect fail_count += 2 and ff_chan = 1.
- Underflow and full: act_valid on an empty channel 2 → ff_cause = 10. Push DEPTH words → exp_ready low; a further push is dropped.
- Count/leftover error: NUM_TESTS=4, 3 passing compares plus one unconsumed expected entry, then finish → test_failed, ff_cause = 11, ff_index = 3.
- Abort and reset: FAIL_LIMIT = 2, two failures → FAILED one cycle after the 2nd failure. Asserting wb_rst_n low mid-RUN clears all outputs asynchronously.
